// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel read scheduler: FSM state encoding and default widths.
package sobel_pkg;

  localparam int OFFSET_W_DFLT        = 18;
  localparam int MAX_OUTSTANDING_DFLT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } t_read_sched_state;

endpackage

// File: rtl/sobel_read_sched_if.sv
// Read-port bundle between the scheduler (master) and the line memory (slave).
interface sobel_read_sched_if import sobel_pkg::*; #(
  parameter int OFFSET_W = OFFSET_W_DFLT
) ();

  logic                rd_req_valid;
  logic [OFFSET_W-1:0] rd_req_offset;
  logic                rd_full;
  logic                rd_rsp_valid;

  modport master (
    output rd_req_valid,
    output rd_req_offset,
    input  rd_full,
    input  rd_rsp_valid
  );

  modport slave (
    input  rd_req_valid,
    input  rd_req_offset,
    output rd_full,
    output rd_rsp_valid
  );

endinterface

// File: rtl/sobel_credit_counter.sv
// In-flight read counter: +1 per accepted request, -1 per response, never below zero.
// A response seen with nothing in flight is dropped and flagged as underflow.
module sobel_credit_counter #(
  parameter int MAX   = 64,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             underflow
);

  logic dec_eff;

  assign underflow = dec && (count == '0);
  assign dec_eff   = dec && !underflow;
  assign full      = (count == CNT_W'(MAX));

  // Track reads in flight; simultaneous inc and effective dec cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({inc, dec_eff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sobel_read_sched.sv
// Sobel line-read scheduler: issues `length` sequential line reads with a cap on
// reads in flight, drains outstanding responses, then flags completion.
// Optional feature: define SOBEL_READ_SCHED_PERF_EN to build the stall_cycles counter;
// without it stall_cycles is tied to zero.
module sobel_read_sched import sobel_pkg::*; #(
  parameter int  OFFSET_W        = OFFSET_W_DFLT,
  parameter int  MAX_OUTSTANDING = MAX_OUTSTANDING_DFLT,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OFFSET_W-1:0] length,
  input  logic                abort,
  sobel_read_sched_if.master  rd,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    outstanding,
  output logic                rsp_error,
  output logic [31:0]         stall_cycles
);

  t_read_sched_state   state_q;
  logic [OFFSET_W-1:0] len_q;
  logic [OFFSET_W-1:0] offset_q;
  logic                cc_full;
  logic                cc_underflow;
  logic                start_ok;
  logic                accept;

  assign start_ok         = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Request valid depends only on registered state and abort, never on rd_full
  assign rd.rd_req_valid  = (state_q == ST_ISSUE) && (offset_q < len_q) && !cc_full && !abort;
  assign rd.rd_req_offset = offset_q;
  assign accept           = rd.rd_req_valid && !rd.rd_full;
  assign busy             = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

  sobel_credit_counter #(
    .MAX   (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .inc       (accept),
    .dec       (rd.rd_rsp_valid),
    .count     (outstanding),
    .full      (cc_full),
    .underflow (cc_underflow)
  );

  // Job length is data: captured on an accepted start, no reset needed
  always_ff @(posedge clk) begin
    if (start_ok) len_q <= length;
  end

  // Job FSM, request offset and sticky done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      offset_q <= '0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            offset_q <= '0;
            if (length == '0) begin
              state_q <= ST_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
              done    <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          if (accept) offset_q <= offset_q + OFFSET_W'(1);
          if (abort || (accept && (offset_q == len_q - OFFSET_W'(1)))) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky response error; a new underflow wins over the clear from start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_error <= 1'b0;
    end else if (cc_underflow) begin
      rsp_error <= 1'b1;
    end else if (start_ok) begin
      rsp_error <= 1'b0;
    end
  end

`ifdef SOBEL_READ_SCHED_PERF_EN
  logic [31:0] stall_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count cycles where a pending request is held off by back-pressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (rd.rd_req_valid && rd.rd_full) begin
      stall_q <= sat_inc32(stall_q);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sobel_read_sched.sv
// Directed bench for sobel_read_sched: a job table run through a response model,
// plus hand sequences for credit limiting, zero-length jobs and mid-job reset.
module tb_sobel_read_sched;

  localparam int OW = 18;
  localparam int MO = 4;
`ifdef SOBEL_READ_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [OW-1:0] length;
  logic          abort;
  logic          busy;
  logic          done;
  logic [2:0]    outstanding;
  logic          rsp_error;
  logic [31:0]   stall_cycles;

  sobel_read_sched_if #(.OFFSET_W(OW)) rd_if ();

  sobel_read_sched #(
    .OFFSET_W        (OW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .length       (length),
    .abort        (abort),
    .rd           (rd_if),
    .busy         (busy),
    .done         (done),
    .outstanding  (outstanding),
    .rsp_error    (rsp_error),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int lat;
    int full_start;
    int full_len;
    int abort_acc;
    int exp_acc;
    int exp_stall;
    int exp_done;
  } job_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One job: start in cycle 0, responses `lat` cycles after each accept.
  task automatic run_job(input job_t j);
    int q[$];
    int acc;
    int stalls;
    int done_cyc;
    acc = 0; stalls = 0; done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; length = OW'(j.len); abort = 1'b0;
    rd_if.rd_full = 1'b0; rd_if.rd_rsp_valid = 1'b0;
    @(negedge clk);
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rd_if.rd_full = (cyc >= j.full_start) && (cyc < j.full_start + j.full_len);
      abort = (j.abort_acc >= 0) && (acc >= j.abort_acc);
      rd_if.rd_rsp_valid = 1'b0;
      if (q.size() > 0 && q[0] <= cyc) begin
        rd_if.rd_rsp_valid = 1'b1;
        void'(q.pop_front());
      end
      @(negedge clk);
      chk("no_overissue", 32'(rd_if.rd_req_valid && (acc >= j.len)), 32'd0);
      if (rd_if.rd_req_valid) begin
        chk("offset", 32'(rd_if.rd_req_offset), 32'(acc));
        if (!rd_if.rd_full) begin
          q.push_back(cyc + j.lat);
          acc++;
        end else begin
          stalls++;
        end
      end
      if (done) done_cyc = cyc;
    end
    rd_if.rd_rsp_valid = 1'b0; rd_if.rd_full = 1'b0; abort = 1'b0;
    chk("job_accepts", 32'(acc), 32'(j.exp_acc));
    chk("job_done_cycle", 32'(done_cyc), 32'(j.exp_done));
    chk("job_stalls_seen", 32'(stalls), 32'(j.exp_stall));
    chk("job_stall_cycles", stall_cycles, PERF ? 32'(j.exp_stall) : 32'd0);
    chk("job_outstanding", 32'(outstanding), 32'd0);
    chk("job_busy", 32'(busy), 32'd0);
    chk("job_rsp_error", 32'(rsp_error), 32'd0);
    chk("job_final_offset", 32'(rd_if.rd_req_offset), 32'(j.exp_acc));
  endtask

  // Advance n cycles from posedge+1, counting accepts with current inputs.
  task automatic cycles(input int n, inout int acc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rd_if.rd_req_valid && !rd_if.rd_full) acc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs[5];
    job_t last_job;
    int   acc;
    int   dmy;

    //        len lat fs fl abort acc stall done
    jobs[0] = '{8,  3, 0, 0, -1,  8, 0,  13};
    jobs[1] = '{1,  1, 0, 0, -1,  1, 0,  4};
    jobs[2] = '{5,  2, 3, 10, -1, 5, 10, 19};
    jobs[3] = '{6,  4, 0, 0,  3,  3, 0,  9};
    jobs[4] = '{3,  1, 0, 0, -1,  3, 0,  6};
    last_job = '{2, 1, 0, 0, -1,  2, 0,  5};

    reset = 1'b1; start = 1'b0; length = '0; abort = 1'b0;
    rd_if.rd_full = 1'b0; rd_if.rd_rsp_valid = 1'b0;
    acc = 0; dmy = 0;
    #12;
    chk("rst_valid", 32'(rd_if.rd_req_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_offset", 32'(rd_if.rd_req_offset), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    reset = 1'b0;

    foreach (jobs[k]) run_job(jobs[k]);

    // Credit limit: 100 lines, MAX_OUTSTANDING=4, no responses yet
    @(posedge clk); #1;
    start = 1'b1; length = OW'(100);
    cycles(1, dmy);
    start = 1'b0; acc = 0;
    cycles(10, acc);
    chk("credit_accepts", 32'(acc), 32'd4);
    chk("credit_outstanding", 32'(outstanding), 32'd4);
    chk("credit_valid_low", 32'(rd_if.rd_req_valid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      rd_if.rd_rsp_valid = 1'b1;
      cycles(1, acc);
      rd_if.rd_rsp_valid = 1'b0;
      cycles(4, acc);
      chk("credit_release", 32'(acc), 32'(5 + k));
    end
    abort = 1'b1;
    rd_if.rd_rsp_valid = 1'b1;
    cycles(4, acc);
    rd_if.rd_rsp_valid = 1'b0;
    chk("abort_no_issue", 32'(acc), 32'd6);
    for (int i = 0; i < 10 && !done; i++) cycles(1, dmy);
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_outstanding", 32'(outstanding), 32'd0);
    chk("abort_rsp_error", 32'(rsp_error), 32'd0);
    chk("abort_offset", 32'(rd_if.rd_req_offset), 32'd6);

    // Zero-length job from a clean reset, then a stray response
    @(posedge clk); #1;
    reset = 1'b1; #2; reset = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; length = '0;
    @(negedge clk);
    chk("len0_done_before", 32'(done), 32'd0);
    chk("len0_busy_c0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy_c1", 32'(busy), 32'd0);
    chk("len0_valid", 32'(rd_if.rd_req_valid), 32'd0);
    cycles(1, dmy);
    chk("len0_busy_c2", 32'(busy), 32'd0);
    rd_if.rd_rsp_valid = 1'b1;
    cycles(1, dmy);
    rd_if.rd_rsp_valid = 1'b0;
    chk("stray_rsp_error", 32'(rsp_error), 32'd1);
    chk("stray_outstanding", 32'(outstanding), 32'd0);

    // Reset in the middle of an issuing job
    @(posedge clk); #1;
    start = 1'b1; length = OW'(6);
    cycles(1, dmy);
    start = 1'b0; acc = 0;
    cycles(3, acc);
    chk("midrst_pre_acc", 32'(acc), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(rd_if.rd_req_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_outstanding", 32'(outstanding), 32'd0);
    chk("midrst_offset", 32'(rd_if.rd_req_offset), 32'd0);
    chk("midrst_rsp_error", 32'(rsp_error), 32'd0);
    chk("midrst_stall", stall_cycles, 32'd0);
    #1 reset = 1'b0;
    rd_if.rd_rsp_valid = 1'b1;
    @(posedge clk); #1;
    rd_if.rd_rsp_valid = 1'b0;
    chk("late_rsp_error", 32'(rsp_error), 32'd1);
    chk("late_rsp_outstanding", 32'(outstanding), 32'd0);
    run_job(last_job);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
